// File: rtl/b08_seq_driver_pkg.sv
// Shared types and sizes for the sequence driver and its byte buffer.
package b08_seq_driver_pkg;

    localparam int unsigned SEQ_LEN = 8;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned RES_W   = 4;
    localparam int unsigned PTR_W   = $clog2(SEQ_LEN);
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_START,
        ST_SEND,
        ST_WAIT,
        ST_CAPTURE
    } state_e;

    // States in which the host may load bytes into the buffer.
    function automatic logic is_load_state(input state_e s);
        return (s == ST_IDLE) || (s == ST_FILL);
    endfunction

endpackage

// File: rtl/b08_seq_buf.sv
// 8x8 byte register file: one synchronous write port, one asynchronous read port.
module b08_seq_buf
    import b08_seq_driver_pkg::*;
(
    input  logic              clock,
    input  logic              we,
    input  logic [PTR_W-1:0]  wp,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [PTR_W-1:0]  rp,
    output logic [BYTE_W-1:0] rdata_c
);

    logic [BYTE_W-1:0] mem_q [SEQ_LEN];

    // Contents are data-only and are not cleared by reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[wp] <= wdata;
        end
    end

    assign rdata_c = mem_q[rp];

endmodule

// File: rtl/b08_seq_driver.sv
// Buffers 8 host bytes, streams them to a consumer on GO, waits, then captures its result nibble.
module b08_seq_driver
    import b08_seq_driver_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_valid,
    input  logic [BYTE_W-1:0] load_data,
    output logic              load_ready,
    input  logic              go,
    output logic              start,
    output logic [BYTE_W-1:0] i,
    input  logic [RES_W-1:0]  o,
    output logic [RES_W-1:0]  result,
    output logic              done,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic              full_q, full_d;
    logic [PTR_W-1:0]  rp_q, rp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_ready_q, load_ready_d;
    logic              start_q, start_d;
    logic [BYTE_W-1:0] i_q, i_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              we_c;
    logic              accept_c;
    logic [BYTE_W-1:0] rdata_c;

    assign accept_c = load_valid && load_ready_q;

    // Byte buffer; read address is the next-cycle pointer so I lines up with the SEND state.
    b08_seq_buf u_buf (
        .clock   (clock),
        .we      (we_c),
        .wp      (wp_q),
        .wdata   (load_data),
        .rp      (rp_d),
        .rdata_c (rdata_c)
    );

    // Next-state, pointer/counter and output-register logic.
    always_comb begin
        state_d  = state_q;
        wp_d     = wp_q;
        full_d   = full_q;
        rp_d     = rp_q;
        cnt_d    = cnt_q;
        we_c     = 1'b0;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (accept_c) begin
                    we_c    = 1'b1;
                    wp_d    = wp_q + PTR_W'(1);
                    state_d = ST_FILL;
                    if (wp_q == PTR_W'(SEQ_LEN - 1)) begin
                        full_d = 1'b1;
                    end
                end else if (go && full_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                rp_d    = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (rp_q == PTR_W'(SEQ_LEN - 1)) begin
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = ST_WAIT;
                end else begin
                    rp_d = rp_q + PTR_W'(1);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                result_d = o;
                done_d   = 1'b1;
                wp_d     = '0;
                full_d   = 1'b0;
                rp_d     = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered from the next state so the outputs align with the state they describe.
        start_d      = (state_d == ST_START);
        busy_d       = !is_load_state(state_d);
        load_ready_d = is_load_state(state_d) && !full_d;
    end

    // Byte stream: buffer data while sending, zero otherwise.
    always_comb begin
        i_d = '0;
        if (state_d == ST_SEND) begin
            i_d = rdata_c;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wp_q         <= '0;
            full_q       <= 1'b0;
            rp_q         <= '0;
            cnt_q        <= '0;
            load_ready_q <= 1'b0;
            start_q      <= 1'b0;
            i_q          <= '0;
            result_q     <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            full_q       <= full_d;
            rp_q         <= rp_d;
            cnt_q        <= cnt_d;
            load_ready_q <= load_ready_d;
            start_q      <= start_d;
            i_q          <= i_d;
            result_q     <= result_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign load_ready = load_ready_q;
    assign start      = start_q;
    assign i          = i_q;
    assign result     = result_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_b08_seq_driver.sv
// Scoreboard bench: default instance plus a WAIT_CYCLES=1 instance with O tied to 4'hA.
module tb_b08_seq_driver;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       load_valid;
    logic [7:0] load_data;
    logic       go;
    logic [3:0] o_val;

    logic       load_ready0, start0, done0, busy0;
    logic [7:0] i0;
    logic [3:0] result0;
    logic       load_ready1, start1, done1, busy1;
    logic [7:0] i1;
    logic [3:0] result1;

    int errors = 0;
    int checks = 0;
    int acc;

    logic [7:0] exp_q[$];
    logic [3:0] res_q[$];

    always #5 clock = ~clock;

    b08_seq_driver dut0 (
        .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready0), .go(go), .start(start0), .i(i0), .o(o_val),
        .result(result0), .done(done0), .busy(busy0)
    );

    b08_seq_driver #(.WAIT_CYCLES(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready1), .go(go), .start(start1), .i(i1), .o(4'hA),
        .result(result1), .done(done1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one byte and hold it until the driver takes it; record it as expected on I.
    task automatic push_byte(input logic [7:0] b);
        int t = 0;
        load_valid = 1'b1;
        load_data  = b;
        while (load_ready0 !== 1'b1 && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (t >= 20) check("ready_timeout", 32'(t), 32'd0);
        exp_q.push_back(b);
        @(negedge clock);
        load_valid = 1'b0;
    endtask

    // Pulse (or hold) GO and score the whole transmit/capture sequence.
    task automatic run_seq(input logic [3:0] o_in, input bit hold_go, input logic [3:0] prev_res);
        int d0 = -1;
        int d1 = -1;
        int restarts = 0;
        logic [7:0] eb;
        logic [3:0] er;
        o_val = o_in;
        res_q.push_back(o_in);
        go = 1'b1;
        @(negedge clock);
        if (!hold_go) go = 1'b0;
        check("start_on", 32'(start0), 32'd1);
        check("start1_on", 32'(start1), 32'd1);
        check("busy_on", 32'(busy0), 32'd1);
        for (int t = 1; t <= 20; t++) begin
            @(negedge clock);
            if (t == 1) check("start_off", 32'(start0), 32'd0);
            if (t <= 8) begin
                eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
                check("i_byte", 32'(i0), 32'(eb));
                check("i1_byte", 32'(i1), 32'(eb));
            end
            if (t == 8) check("result_hold", 32'(result0), 32'(prev_res));
            if (t == 9) check("i_zero_wait", 32'(i0), 32'd0);
            if (t >= 9 && start0) restarts++;
            if (done0 && d0 < 0) d0 = t;
            if (done1 && d1 < 0) d1 = t;
        end
        check("done_lat", 32'(d0), 32'd12);
        check("done1_lat", 32'(d1), 32'd11);
        check("no_retrigger", 32'(restarts), 32'd0);
        check("busy_after", 32'(busy0), 32'd0);
        er = (res_q.size() > 0) ? res_q.pop_front() : 4'hE;
        check("result", 32'(result0), 32'(er));
        check("result1", 32'(result1), 32'hA);
        go = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        go         = 1'b0;
        o_val      = '0;
        repeat (2) @(negedge clock);
        check("rst_outs0", 32'({start0, i0, result0, done0, busy0, load_ready0}), 32'd0);
        check("rst_outs1", 32'({start1, i1, result1, done1, busy1, load_ready1}), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("ready_after_rst", 32'(load_ready0), 32'd1);
        check("ready1_after_rst", 32'(load_ready1), 32'd1);

        // GO with only 5 bytes buffered is ignored.
        for (int k = 1; k <= 5; k++) push_byte(8'(k));
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        repeat (3) begin
            check("short_no_start", 32'(start0), 32'd0);
            check("short_no_busy", 32'(busy0), 32'd0);
            @(negedge clock);
        end

        // GO alongside the 8th byte (7 buffered) is ignored; the byte is taken.
        push_byte(8'h06);
        push_byte(8'h07);
        go = 1'b1;
        push_byte(8'h08);
        go = 1'b0;
        check("go_with_7_ignored", 32'(start0), 32'd0);
        check("ready_drop_full", 32'(load_ready0), 32'd0);
        @(negedge clock);
        check("full_idle_busy", 32'(busy0), 32'd0);
        run_seq(4'h5, 1'b0, 4'h0);

        // LOAD_VALID held across 10 offers: exactly 8 accepted.
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            load_valid = 1'b1;
            load_data  = 8'h10 + 8'(k);
            if (load_ready0) begin
                exp_q.push_back(load_data);
                acc++;
            end
            @(negedge clock);
        end
        load_valid = 1'b0;
        check("accept_count", 32'(acc), 32'd8);
        check("ready_low_full", 32'(load_ready0), 32'd0);
        run_seq(4'h9, 1'b1, 4'h5);

        // Reset in the middle of SEND.
        for (int k = 0; k < 8; k++) push_byte(8'h20 + 8'(k));
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        check("rs_start", 32'(start0), 32'd1);
        repeat (5) @(negedge clock);
        check("i_rp4", 32'(i0), 32'h24);
        reset_n = 1'b0;
        #1;
        check("midsend_rst0", 32'({start0, i0, result0, done0, busy0, load_ready0}), 32'd0);
        check("midsend_rst1", 32'({start1, i1, result1, done1, busy1, load_ready1}), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.delete();
        res_q.delete();
        @(negedge clock);
        check("ready_after_rst2", 32'(load_ready0), 32'd1);
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        repeat (3) begin
            check("post_rst_no_start", 32'(start0), 32'd0);
            check("post_rst_no_busy", 32'(busy0), 32'd0);
            @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
